// File: rtl/gate_tt_checker_pkg.sv
// Shared definitions for the gate truth-table checker: FSM state encodings
// and the expected truth tables of the library's 2-input gates.
package gate_tt_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // Bit n holds the gate output for {I0,I1} = n.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_tt_settle_timer.sv
// Load/count/expire down-counter that paces how long each test vector is held
// on the gate under test before it is sampled.
module gate_tt_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with SETTLE_CYCLES-1, so expiry falls on the last settle cycle.
  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Drives all four input vectors onto a 2-input gate, samples its output and
// compares the captured truth table against the expected one.
// Optional macro GATE_TT_CHECKER_STICKY_EN adds a fail flag held until reset.
module gate_tt_checker
  import gate_tt_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [3:0] Expected,
  input  logic       Out,
  output logic       I0,
  output logic       I1,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [3:0] Observed,
  output logic [3:0] FailMask,
  output logic       StickyFail
);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] exp_q, exp_d;
  logic [3:0] obs_q, obs_d;
  logic [3:0] fm_q, fm_d;
  logic       pass_q, pass_d;
  logic       tmr_load, tmr_en, tmr_expire;

  assign tmr_load = ((state_q == ST_IDLE) && Start) ||
                    ((state_q == ST_SAMPLE) && (idx_q != 2'd3));
  assign tmr_en   = (state_q == ST_SETTLE);

  gate_tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (tmr_load),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    obs_d   = obs_q;
    fm_d    = fm_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_SETTLE;
          exp_d   = Expected;
          idx_d   = 2'd0;
          obs_d   = 4'd0;
          fm_d    = 4'd0;
          pass_d  = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (tmr_expire) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        obs_d[idx_q] = Out;
        if (idx_q == 2'd3) begin
          // Verdict uses the table including the sample taken this edge.
          state_d = ST_REPORT;
          pass_d  = (obs_d == exp_q);
          fm_d    = obs_d ^ exp_q;
        end else begin
          state_d = ST_SETTLE;
          idx_d   = idx_q + 2'd1;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      exp_q   <= 4'd0;
      obs_q   <= 4'd0;
      fm_q    <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      obs_q   <= obs_d;
      fm_q    <= fm_d;
      pass_q  <= pass_d;
    end
  end

  assign I0       = idx_q[1];
  assign I1       = idx_q[0];
  assign Busy     = (state_q != ST_IDLE);
  assign Done     = (state_q == ST_REPORT);
  assign Pass     = pass_q;
  assign Observed = obs_q;
  assign FailMask = fm_q;

`ifdef GATE_TT_CHECKER_STICKY_EN
  logic sticky_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sticky_q <= 1'b0;
    end else if ((state_q == ST_REPORT) && !pass_q) begin
      sticky_q <= 1'b1;
    end
  end

  assign StickyFail = sticky_q;
`else
  assign StickyFail = 1'b0;
`endif

endmodule
